// File: rtl/mem_bus_if_pkg.sv
// mem_bus_if_pkg
// Shared constants for the memory bus interface and the control unit (cu2).
// Holds the bus FSM state encoding, the default address/data widths, the
// default request timeout and the width of the wait counter.
package mem_bus_if_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 15;

    // Wide enough for any TIMEOUT in 1..15
    localparam int TIMER_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } bus_state_t;

endpackage

// File: rtl/mem_bus_if_wait_timer.sv
// wait_timer
// Counts the cycles a memory request has been outstanding without an ack.
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-low reset
//   clear   - restart the count at zero (new request accepted)
//   enable  - advance the count by one this cycle
//   expired - high when the count has reached TIMEOUT-1
module wait_timer
    import mem_bus_if_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_if.sv
// mem_bus_if
// Memory bus interface between the CPU datapath and a ready/ack memory.
// Holds the address register (MAR) and memory data register (MDR), issues
// registered read/write requests and aborts requests that are never acked.
// Ports:
//   clk, rst                 - clock and asynchronous active-low reset
//   load_Add_R, bus_in       - load MAR from the datapath (IDLE/DONE only)
//   read, write, wdata       - start an access at MAR (write wins if both)
//   err_clr                  - clear the sticky bus_err flag
//   mem_ready                - high when the next access may be issued
//   rdata, rdata_valid       - MDR contents and fresh-read-data pulse
//   bus_err                  - sticky timeout flag
//   mem_req, mem_we          - registered request / write enable
//   mem_addr, mem_wdata      - registered address / write data
//   mem_ack, mem_rdata       - memory response
module mem_bus_if
    import mem_bus_if_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_Add_R,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] bus_in,
    input  logic [DATA_W-1:0] wdata,
    input  logic              err_clr,
    output logic              mem_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    bus_state_t        state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              bus_err_q, bus_err_d;
    // Remembers whether the access in flight is a read, so DONE knows
    // whether to pulse rdata_valid and REQ knows whether to load MDR.
    logic              is_read_q, is_read_d;

    logic              timer_clear;
    logic              timer_en;
    logic              timer_expired;

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        mar_d       = mar_q;
        mdr_d       = mdr_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        bus_err_d   = bus_err_q;
        is_read_d   = is_read_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;

        // The timeout branch below sets bus_err after this, so a timeout
        // in the same cycle as err_clr leaves the flag set.
        if (err_clr) begin
            bus_err_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (load_Add_R) begin
                    mar_d = bus_in;
                end
                // Request takes the MAR value from before any same-cycle load
                if (read || write) begin
                    state_d     = REQ;
                    mem_addr_d  = mar_q;
                    mem_we_d    = write;
                    mem_wdata_d = wdata;
                    mem_req_d   = 1'b1;
                    is_read_d   = !write;
                    timer_clear = 1'b1;
                end
            end
            REQ: begin
                // Ack has priority over a coincident timeout
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (is_read_q) begin
                        mdr_d = mem_rdata;
                    end
                    state_d = DONE;
                end else if (timer_expired) begin
                    // Write enable is dropped with the request so memory
                    // never sees a stale write strobe.
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (is_read_q) begin
                        mdr_d = '1;
                    end
                    bus_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            DONE: begin
                if (load_Add_R) begin
                    mar_d = bus_in;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mar_q       <= '0;
            mdr_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            bus_err_q   <= 1'b0;
            is_read_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mar_q       <= mar_d;
            mdr_q       <= mdr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            bus_err_q   <= bus_err_d;
            is_read_q   <= is_read_d;
        end
    end

    assign mem_ready   = (state_q == IDLE) || (state_q == DONE);
    assign rdata_valid = (state_q == DONE) && is_read_q;
    assign rdata       = mdr_q;
    assign bus_err     = bus_err_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_if.sv
// tb_mem_bus_if
// Directed bench for mem_bus_if with default parameters (8-bit address and
// data, TIMEOUT=15). Inputs change on the falling edge and outputs are
// compared on the falling edge, half a cycle away from the active edge.
module tb_mem_bus_if;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_Add_R;
    logic       read;
    logic       write;
    logic [7:0] bus_in;
    logic [7:0] wdata;
    logic       err_clr;
    logic       mem_ready;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       bus_err;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_ack;
    logic [7:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_bus_if dut (
        .clk         (clk),
        .rst         (rst),
        .load_Add_R  (load_Add_R),
        .read        (read),
        .write       (write),
        .bus_in      (bus_in),
        .wdata       (wdata),
        .err_clr     (err_clr),
        .mem_ready   (mem_ready),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .bus_err     (bus_err),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Loads MAR with addr over one cycle, returning at a falling edge
    task automatic load_mar(input logic [7:0] addr);
        load_Add_R = 1'b1;
        bus_in     = addr;
        @(negedge clk);
        load_Add_R = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        load_Add_R = 1'b0; read = 1'b0; write = 1'b0;
        bus_in = 8'h00; wdata = 8'h00; err_clr = 1'b0;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        #12;
        n_checks++;
        if ({mem_ready, rdata_valid, bus_err, mem_req, mem_we} !== 5'b10000) begin
            n_fail++;
            $display("[TB] FAIL reset_flags got=%b expected=10000",
                     {mem_ready, rdata_valid, bus_err, mem_req, mem_we});
        end
        n_checks++;
        if ({rdata, mem_addr, mem_wdata} !== 24'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_data got=%h expected=000000",
                     {rdata, mem_addr, mem_wdata});
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        load_mar(8'h10);
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        n_checks++;
        if ({mem_req, mem_we, mem_ready, mem_addr} !== {3'b100, 8'h10}) begin
            n_fail++;
            $display("[TB] FAIL read_req got=%b_%h expected=100_10",
                     {mem_req, mem_we, mem_ready}, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 8'hA5;
        @(negedge clk);
        mem_ack = 1'b0;
        n_checks++;
        if ({rdata_valid, mem_ready, mem_req, rdata} !== {3'b110, 8'hA5}) begin
            n_fail++;
            $display("[TB] FAIL read_done got=%b_%h expected=110_a5",
                     {rdata_valid, mem_ready, mem_req}, rdata);
        end
        @(negedge clk);
        n_checks++;
        if ({rdata_valid, mem_ready, rdata} !== {2'b01, 8'hA5}) begin
            n_fail++;
            $display("[TB] FAIL read_pulse_end got=%b_%h expected=01_a5",
                     {rdata_valid, mem_ready}, rdata);
        end
    endtask

    task automatic test_write();
        load_mar(8'h20);
        write = 1'b1; wdata = 8'h3C;
        @(negedge clk);
        write = 1'b0; wdata = 8'h00;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({mem_req, mem_we, rdata_valid, mem_addr, mem_wdata} !== {3'b110, 8'h20, 8'h3C}) begin
                n_fail++;
                $display("[TB] FAIL write_hold[%0d] got=%b_%h_%h expected=110_20_3c",
                         i, {mem_req, mem_we, rdata_valid}, mem_addr, mem_wdata);
            end
            if (i == 3) mem_ack = 1'b1;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        n_checks++;
        if ({mem_req, mem_we, rdata_valid, mem_ready, rdata} !== {4'b0001, 8'hA5}) begin
            n_fail++;
            $display("[TB] FAIL write_done got=%b_%h expected=0001_a5",
                     {mem_req, mem_we, rdata_valid, mem_ready}, rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int cycles = 0;
        load_mar(8'h30);
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mem_req !== 1'b1) break;
            cycles++;
            @(negedge clk);
        end
        n_checks++;
        if (cycles != 15) begin
            n_fail++;
            $display("[TB] FAIL timeout_len got=%0d expected=15", cycles);
        end
        n_checks++;
        if ({bus_err, rdata_valid, rdata} !== {2'b11, 8'hFF}) begin
            n_fail++;
            $display("[TB] FAIL timeout_abort got=%b_%h expected=11_ff",
                     {bus_err, rdata_valid}, rdata);
        end
        // Late ack arriving in IDLE must be ignored
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 8'h12;
        repeat (2) @(negedge clk);
        mem_ack = 1'b0;
        n_checks++;
        if ({bus_err, mem_req, mem_ready, rdata} !== {3'b101, 8'hFF}) begin
            n_fail++;
            $display("[TB] FAIL timeout_sticky got=%b_%h expected=101_ff",
                     {bus_err, mem_req, mem_ready}, rdata);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_checks++;
        if (bus_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL err_clr got=%b expected=0", bus_err);
        end
    endtask

    task automatic test_err_clr_collision();
        int cycles = 0;
        // err_clr held through the whole request: the timeout must still win
        err_clr = 1'b1;
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mem_req !== 1'b1) break;
            cycles++;
            @(negedge clk);
        end
        err_clr = 1'b0;
        n_checks++;
        if ({cycles == 15, bus_err} !== 2'b11) begin
            n_fail++;
            $display("[TB] FAIL err_clr_collision cycles=%0d bus_err=%b expected=15/1",
                     cycles, bus_err);
        end
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        // Ack in the last allowed cycle completes normally
        cycles = 0;
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mem_req !== 1'b1) break;
            cycles++;
            if (cycles == 15) begin
                mem_ack = 1'b1; mem_rdata = 8'h6B;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        n_checks++;
        if ({cycles == 15, bus_err, rdata_valid, rdata} !== {3'b101, 8'h6B}) begin
            n_fail++;
            $display("[TB] FAIL ack_at_timeout cycles=%0d got=%b_%b_%h expected=15/0_1_6b",
                     cycles, bus_err, rdata_valid, rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_rw_priority();
        load_mar(8'h40);
        read = 1'b1; write = 1'b1; wdata = 8'h77;
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 8'h40, 8'h77}) begin
            n_fail++;
            $display("[TB] FAIL rw_write_wins got=%b_%h_%h expected=11_40_77",
                     {mem_req, mem_we}, mem_addr, mem_wdata);
        end
        // MAR load during REQ must be ignored
        load_mar(8'h55);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        n_checks++;
        if ({rdata_valid, mem_ready} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL rw_done got=%b expected=01", {rdata_valid, mem_ready});
        end
        @(negedge clk);
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        n_checks++;
        if ({mem_req, mem_we, mem_addr} !== {2'b10, 8'h40}) begin
            n_fail++;
            $display("[TB] FAIL mar_unchanged got=%b_%h expected=10_40",
                     {mem_req, mem_we}, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 8'h99;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        n_checks++;
        if (rdata !== 8'h99) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_mdr got=%h expected=99", rdata);
        end
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({mem_req, mem_ready, rdata_valid, rdata, mem_addr} !== {3'b010, 8'h00, 8'h00}) begin
            n_fail++;
            $display("[TB] FAIL reset_mid got=%b_%h_%h expected=010_00_00",
                     {mem_req, mem_ready, rdata_valid}, rdata, mem_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        mem_ack = 1'b1; mem_rdata = 8'hEE;
        repeat (2) @(negedge clk);
        mem_ack = 1'b0;
        n_checks++;
        if ({mem_req, mem_ready, rdata_valid, rdata} !== {3'b010, 8'h00}) begin
            n_fail++;
            $display("[TB] FAIL late_ack_ignored got=%b_%h expected=010_00",
                     {mem_req, mem_ready, rdata_valid}, rdata);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_err_clr_collision();
        test_rw_priority();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global guard so the run always terminates
    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout expected=completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
